// File: rtl/i2c_slave_if.sv
// Register-write notification and busy status from the I2C target to its host logic.
interface i2c_slave_if #(parameter int AW = 4);
    logic          busy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    modport slave  (output busy, output wr_en, output wr_addr, output wr_data);
    modport master (input  busy, input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/i2c_slave.sv
// Oversampled I2C target: 7-bit address match, pointer byte, auto-incrementing 16x8 register file.
// Bus events act 3 clk after the pad edge; SCL is never stretched.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h66,
    parameter int         DEPTH      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl,
    inout  wire           sda,
    i2c_slave_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t        state;
    logic          scl_s1, scl_s2, scl_d;
    logic          sda_s1, sda_s2, sda_d;
    logic [7:0]    sh, tx;
    logic [2:0]    bit_cnt;
    logic          ack_ph, rw, sda_low, busy, wr_en;
    logic [AW-1:0] ptr, wr_addr;
    logic [7:0]    wr_data;
    logic [7:0]    regs [DEPTH];

    logic          scl_rise, scl_fall, start, stop;
    logic [7:0]    sh_nxt;
    logic [AW-1:0] ptr_inc;

    assign sda = sda_low ? 1'b0 : 1'bz;

    assign bus.busy    = busy;
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;

    // Sync FFs idle high so reset release does not fake a bus condition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
        end else begin
            scl_s1 <= scl;    scl_s2 <= scl_s1; scl_d <= scl_s2;
            sda_s1 <= sda;    sda_s2 <= sda_s1; sda_d <= sda_s2;
        end
    end

    assign scl_rise = scl_s2 & ~scl_d;
    assign scl_fall = ~scl_s2 & scl_d;
    assign start    = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop     = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign sh_nxt   = {sh[6:0], sda_s2};
    assign ptr_inc  = ptr + AW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sh      <= '0;
            tx      <= '0;
            bit_cnt <= '0;
            ack_ph  <= 1'b0;
            rw      <= 1'b0;
            sda_low <= 1'b0;
            busy    <= 1'b0;
            wr_en   <= 1'b0;
            ptr     <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                ADDR: if (scl_rise) begin
                    sh      <= sh_nxt;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (sh_nxt[7:1] == SLAVE_ADDR) begin
                            state <= ADDR_ACK;
                            busy  <= 1'b1;
                            rw    <= sh_nxt[0];
                        end else begin
                            state <= IGNORE;
                            busy  <= 1'b0;
                        end
                    end
                end
                // ACK phases: first fall pulls SDA low, second fall releases it
                ADDR_ACK: if (scl_fall) begin
                    if (!ack_ph) begin
                        ack_ph  <= 1'b1;
                        sda_low <= 1'b1;
                    end else begin
                        ack_ph  <= 1'b0;
                        bit_cnt <= '0;
                        if (rw) begin
                            state   <= RDATA;
                            tx      <= regs[ptr];
                            sda_low <= ~regs[ptr][7];
                        end else begin
                            state   <= REG;
                            sda_low <= 1'b0;
                        end
                    end
                end
                REG: if (scl_rise) begin
                    sh      <= sh_nxt;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        ptr   <= sh_nxt[AW-1:0];
                        state <= REG_ACK;
                    end
                end
                REG_ACK, WDATA_ACK: if (scl_fall) begin
                    if (!ack_ph) begin
                        ack_ph  <= 1'b1;
                        sda_low <= 1'b1;
                    end else begin
                        ack_ph  <= 1'b0;
                        sda_low <= 1'b0;
                        bit_cnt <= '0;
                        state   <= WDATA;
                    end
                end
                WDATA: if (scl_rise) begin
                    sh      <= sh_nxt;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        regs[ptr] <= sh_nxt;
                        wr_en     <= 1'b1;
                        wr_addr   <= ptr;
                        wr_data   <= sh_nxt;
                        ptr       <= ptr_inc;
                        state     <= WDATA_ACK;
                    end
                end
                // tx[7] is always the bit on the wire; the shift exposes the next one
                RDATA: if (scl_fall) begin
                    tx      <= {tx[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        sda_low <= 1'b0;
                        state   <= RDATA_ACK;
                    end else begin
                        sda_low <= ~tx[6];
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise && !ack_ph) begin
                        ptr <= ptr_inc;
                        if (!sda_s2) begin
                            ack_ph <= 1'b1;
                            tx     <= regs[ptr_inc];
                        end else begin
                            state <= IGNORE;
                            busy  <= 1'b0;
                        end
                    end else if (scl_fall && ack_ph) begin
                        ack_ph  <= 1'b0;
                        bit_cnt <= '0;
                        sda_low <= ~tx[7];
                        state   <= RDATA;
                    end
                end
                IDLE, IGNORE: ;
                default: state <= IDLE;
            endcase

            // Bus conditions override the per-state update; a byte commit above still lands
            if (stop) begin
                state   <= IDLE;
                busy    <= 1'b0;
                sda_low <= 1'b0;
                ack_ph  <= 1'b0;
                bit_cnt <= '0;
            end
            if (start) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_low <= 1'b0;
                ack_ph  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged master, scoreboard queues for writes and read bytes.
module tb_i2c_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave_if #(.AW(4)) bus ();

    i2c_slave dut (
        .clk (clk),
        .rst (rst),
        .scl (m_scl),
        .sda (sda),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [11:0] wr_q [$];
    logic [7:0]  rd_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every wr_en cycle must match the next queued write
    always @(negedge clk) begin
        if (!rst && bus.wr_en === 1'b1) begin
            if (wr_q.size() == 0)
                check("wr_unexpected", {20'h0, bus.wr_addr, bus.wr_data}, 32'hFFFF_FFFF);
            else
                check("wr_evt", {20'h0, bus.wr_addr, bus.wr_data}, {20'h0, wr_q.pop_front()});
        end
    end

    task automatic q();
        repeat (4) @(negedge clk);
    endtask

    task automatic start_c();
        m_sda_low = 1'b0; q();
        m_scl = 1'b1;     q();
        m_sda_low = 1'b1; q();
        m_scl = 1'b0;     q();
    endtask

    task automatic stop_c();
        m_sda_low = 1'b1; q();
        m_scl = 1'b1;     q();
        m_sda_low = 1'b0; q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda_low = ~b[i]; q();
            m_scl = 1'b1;      q(); q();
            m_scl = 1'b0;      q();
        end
        m_sda_low = 1'b0; q();
        m_scl = 1'b1;     q();
        ack = sda;        q();
        m_scl = 1'b0;     q();
    endtask

    task automatic recv_byte(input logic ack_low, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda_low = 1'b0; q();
            m_scl = 1'b1;     q();
            b[i] = sda;       q();
            m_scl = 1'b0;     q();
        end
        m_sda_low = ack_low; q();
        m_scl = 1'b1;        q(); q();
        m_scl = 1'b0;
        m_sda_low = 1'b0;    q();
    endtask

    task automatic send_chk(input string tag, input logic [7:0] b, input logic exp_ack);
        logic a;
        send_byte(b, a);
        check(tag, {31'h0, a}, {31'h0, exp_ack});
    endtask

    task automatic read_chk(input string tag, input logic ack_low);
        logic [7:0] b;
        recv_byte(ack_low, b);
        if (rd_q.size() == 0) check({tag, "_noexp"}, {24'h0, b}, 32'hFFFF_FFFF);
        else                  check(tag, {24'h0, b}, {24'h0, rd_q.pop_front()});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sda",     {31'h0, sda},          32'h1);
        check("rst_busy",    {31'h0, bus.busy},     32'h0);
        check("rst_wr_en",   {31'h0, bus.wr_en},    32'h0);
        check("rst_wr_addr", {28'h0, bus.wr_addr},  32'h0);
        check("rst_wr_data", {24'h0, bus.wr_data},  32'h0);
        rst = 1'b0;
        q();

        // Single write regs[1]=B7
        wr_q.push_back({4'h1, 8'hB7});
        start_c();
        send_chk("t1_addr_ack", 8'hCC, 1'b0);
        check("t1_busy_on", {31'h0, bus.busy}, 32'h1);
        send_chk("t1_ptr_ack",  8'h01, 1'b0);
        send_chk("t1_data_ack", 8'hB7, 1'b0);
        stop_c(); q();
        check("t1_busy_off", {31'h0, bus.busy}, 32'h0);
        check("t1_wr_done",  wr_q.size(), 32'h0);

        // Combined read from 0x81 -> index 1
        start_c();
        send_chk("t2_addr_ack", 8'hCC, 1'b0);
        send_chk("t2_ptr_ack",  8'h81, 1'b0);
        start_c();
        send_chk("t2_raddr_ack", 8'hCD, 1'b0);
        rd_q.push_back(8'hB7);
        read_chk("t2_rd", 1'b0 ? 1'b0 : 1'b0);
        check("t2_sda_rel", {31'h0, sda}, 32'h1);
        stop_c(); q();
        check("t2_busy_off", {31'h0, bus.busy},    32'h0);
        check("t2_wr_addr_hold", {28'h0, bus.wr_addr}, 32'h1);
        check("t2_wr_data_hold", {24'h0, bus.wr_data}, 32'hB7);

        // Current-address read: pointer advanced to 2 after the NACKed byte
        start_c();
        send_chk("t2b_raddr_ack", 8'hCD, 1'b0);
        rd_q.push_back(8'h00);
        read_chk("t2b_rd", 1'b0);
        stop_c(); q();

        // Burst write with wrap 15 -> 0
        wr_q.push_back({4'hF, 8'h6A});
        wr_q.push_back({4'h0, 8'h4E});
        start_c();
        send_chk("t3_addr_ack", 8'hCC, 1'b0);
        send_chk("t3_ptr_ack",  8'h0F, 1'b0);
        send_chk("t3_d0_ack",   8'h6A, 1'b0);
        send_chk("t3_d1_ack",   8'h4E, 1'b0);
        stop_c(); q();
        check("t3_wr_done", wr_q.size(), 32'h0);

        // Pointer wrapped then advanced to 1
        start_c();
        send_chk("t3b_raddr_ack", 8'hCD, 1'b0);
        rd_q.push_back(8'hB7);
        read_chk("t3b_rd", 1'b0);
        stop_c(); q();

        // Burst read of regs[0..2]
        wr_q.push_back({4'h0, 8'h11});
        wr_q.push_back({4'h1, 8'h22});
        wr_q.push_back({4'h2, 8'h33});
        start_c();
        send_chk("t4w_addr_ack", 8'hCC, 1'b0);
        send_chk("t4w_ptr_ack",  8'h00, 1'b0);
        send_chk("t4w_d0_ack",   8'h11, 1'b0);
        send_chk("t4w_d1_ack",   8'h22, 1'b0);
        send_chk("t4w_d2_ack",   8'h33, 1'b0);
        stop_c(); q();
        check("t4w_wr_done", wr_q.size(), 32'h0);
        start_c();
        send_chk("t4_addr_ack", 8'hCC, 1'b0);
        send_chk("t4_ptr_ack",  8'h00, 1'b0);
        start_c();
        send_chk("t4_raddr_ack", 8'hCD, 1'b0);
        rd_q.push_back(8'h11);
        rd_q.push_back(8'h22);
        rd_q.push_back(8'h33);
        read_chk("t4_rd0", 1'b1);
        read_chk("t4_rd1", 1'b1);
        read_chk("t4_rd2", 1'b0);
        check("t4_sda_rel", {31'h0, sda}, 32'h1);
        stop_c(); q();
        check("t4_busy_off", {31'h0, bus.busy}, 32'h0);

        // Address mismatch
        start_c();
        send_chk("t5_addr_nack", 8'h9C, 1'b1);
        check("t5_busy", {31'h0, bus.busy}, 32'h0);
        send_chk("t5_data_nack", 8'h55, 1'b1);
        stop_c(); q();
        check("t5_busy_end", {31'h0, bus.busy}, 32'h0);

        // Reset while the slave drives bit 7 (=0) of 0x11
        start_c();
        send_chk("t6_addr_ack", 8'hCC, 1'b0);
        send_chk("t6_ptr_ack",  8'h00, 1'b0);
        start_c();
        send_chk("t6_raddr_ack", 8'hCD, 1'b0);
        check("t6_sda_driven", {31'h0, sda}, 32'h0);
        check("t6_busy_pre", {31'h0, bus.busy}, 32'h1);
        rst = 1'b1;
        #1;
        check("t6_sda_rel", {31'h0, sda},      32'h1);
        check("t6_busy_rst", {31'h0, bus.busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        q();
        start_c();
        send_chk("t6b_raddr_ack", 8'hCD, 1'b0);
        rd_q.push_back(8'h00);
        read_chk("t6b_rd", 1'b0);
        stop_c(); q();
        check("t6b_busy_off", {31'h0, bus.busy}, 32'h0);
        check("end_wr_q", wr_q.size(), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
